// File: rtl/kb_mailbox_writer_pkg.sv
// Shared types, field positions and the mailbox word formatter for kb_mailbox_writer.
// The mailbox word is {16'h0, seq[3:0], 3'b000, valid, code[7:0]}.
package kb_mbox_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int         VALID_BIT  = 8;
    localparam int         SEQ_LSB    = 12;
    localparam int         SEQ_W      = 4;
    localparam logic [7:0] BREAK_CODE = 8'hF0;

    typedef struct packed {
        state_t           state;
        logic [SEQ_W-1:0] seq;
    } kb_dbg_t;

    // The valid bit keeps the word nonzero even for scan code 8'h00.
    function automatic logic [31:0] fmt_mbox(input logic [SEQ_W-1:0] seq, input logic [7:0] code);
        logic [31:0] word;
        word                     = 32'h0;
        word[7:0]                = code;
        word[VALID_BIT]          = 1'b1;
        word[SEQ_LSB +: SEQ_W]   = seq;
        return word;
    endfunction

endpackage

// File: rtl/kb_mailbox_writer_if.sv
// Bundle of the scan-code input, mailbox readback and memory write port of kb_mailbox_writer.
// master = the mailbox writer, slave = the decoder / memory / CPU side.
interface kb_mailbox_writer_if #(
    parameter int FIFO_DEPTH = 4
) ();
    import kb_mbox_pkg::*;

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    // key_valid is a one-cycle strobe with no ready: every strobe is taken, and a key
    // that finds the buffer full is dropped and flagged in overflow. we_kb is a one-cycle
    // write with no acknowledge; memory commits data_kb on the edge that ends the pulse.
    logic             key_valid;
    logic [7:0]       key_code;
    logic [31:0]      code_key;
    logic             ovf_clr;
    logic             we_kb;
    logic [31:0]      addr_kb;
    logic [31:0]      data_kb;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             overflow;
    logic             busy;
    kb_dbg_t          dbg;

    modport master (
        input  key_valid, key_code, code_key, ovf_clr,
        output we_kb, addr_kb, data_kb, fifo_count, fifo_full, overflow, busy, dbg
    );

    modport slave (
        output key_valid, key_code, code_key, ovf_clr,
        input  we_kb, addr_kb, data_kb, fifo_count, fifo_full, overflow, busy, dbg
    );

endinterface

// File: rtl/kb_mailbox_writer_fifo.sv
// Small synchronous FIFO for scan codes; DEPTH must be a power of two so pointers wrap naturally.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module kb_fifo #(
    parameter  int DEPTH = 4,
    parameter  int W     = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CNT_W = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [W-1:0]     din,
    output logic [W-1:0]     dout,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/kb_mailbox_writer.sv
// Keyboard-side mailbox writer: buffers scan codes and writes one at a time into the mailbox
// word once the CPU has cleared it. Optional break-code filtering under KB_BREAK_FILTER_EN.
module kb_mailbox_writer
    import kb_mbox_pkg::*;
#(
    parameter logic [31:0] MBOX_ADDR  = 32'h0000_00F0,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    kb_mailbox_writer_if.master  mb
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_t           state;
    logic [SEQ_W-1:0] seq;
    logic             we_r;
    logic [31:0]      data_r;
    logic             ovf_r;

    logic             push;
    logic             pop;
    logic             drop;
    logic             mbox_free;
    logic [7:0]       head;
    logic [CNT_W-1:0] count;
    logic             fifo_full;
    logic             fifo_empty;

`ifdef KB_BREAK_FILTER_EN
    // F0 arms a one-shot skip that swallows the released key's code that follows it.
    logic skip;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            skip <= 1'b0;
        end else if (mb.key_valid) begin
            skip <= skip ? 1'b0 : (mb.key_code == BREAK_CODE);
        end
    end

    assign push = mb.key_valid && !skip && (mb.key_code != BREAK_CODE);
`else
    assign push = mb.key_valid;
`endif

    assign pop       = (state == WRITE);
    assign drop      = push && fifo_full && !pop;
    assign mbox_free = (mb.code_key == 32'h0);

    kb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (mb.key_code),
        .dout  (head),
        .count (count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // HOLD gives the memory one edge to commit, so IDLE never acts on the pre-write code_key.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            we_r   <= 1'b0;
            data_r <= 32'h0;
            seq    <= '0;
        end else begin
            if (!fifo_empty) data_r <= fmt_mbox(seq, head);
            case (state)
                IDLE: begin
                    if (!fifo_empty && mbox_free) begin
                        state <= WRITE;
                        we_r  <= 1'b1;
                    end
                end
                WRITE: begin
                    state <= HOLD;
                    we_r  <= 1'b0;
                    seq   <= seq + SEQ_W'(1);
                end
                HOLD: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    we_r  <= 1'b0;
                end
            endcase
        end
    end

    // A new drop outranks a clear in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_r <= 1'b0;
        end else if (drop) begin
            ovf_r <= 1'b1;
        end else if (mb.ovf_clr) begin
            ovf_r <= 1'b0;
        end
    end

    assign mb.we_kb      = we_r;
    assign mb.addr_kb    = MBOX_ADDR;
    assign mb.data_kb    = data_r;
    assign mb.fifo_count = count;
    assign mb.fifo_full  = fifo_full;
    assign mb.overflow   = ovf_r;
    assign mb.busy       = (state != IDLE);
    assign mb.dbg        = '{state: state, seq: seq};

endmodule

// File: tb/tb_kb_mailbox_writer.sv
// Bench for kb_mailbox_writer: directed scenarios plus random traffic checked against a
// queue model of the key buffer, sequence counter and overflow flag.
`timescale 1ns/1ps
module tb_kb_mailbox_writer;
    import kb_mbox_pkg::*;

    localparam int          DEPTH = 4;
    localparam logic [31:0] MBOX  = 32'h0000_00F0;

    logic        clk      = 1'b0;
    logic        rst      = 1'b0;
    logic        cpu_clr  = 1'b0;
    logic [31:0] mem_word = 32'h0;
    logic [31:0] wr_log[$];
    int          n_total  = 0;
    int          n_bad    = 0;

    logic [7:0]  exp_q[$];
    logic [3:0]  m_seq    = 4'd0;
    logic        m_ovf    = 1'b0;
    logic        m_skip   = 1'b0;
    logic        prev_we  = 1'b0;
    int          wait_cnt = 0;

    kb_mailbox_writer_if #(.FIFO_DEPTH(DEPTH)) mb ();

    kb_mailbox_writer #(
        .MBOX_ADDR  (MBOX),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .mb  (mb)
    );

    // clock / memory
    always #5 clk = ~clk;

    assign mb.code_key = mem_word;

    always @(posedge clk) begin
        if (mb.we_kb && mb.addr_kb == MBOX) begin
            mem_word <= mb.data_kb;
            wr_log.push_back(mb.data_kb);
        end else if (cpu_clr) begin
            mem_word <= 32'h0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input logic [3:0] s, input logic [7:0] c);
        return {16'h0000, s, 3'b000, 1'b1, c};
    endfunction

    // scoreboard: check current outputs, then advance the model across the coming edge
    always @(negedge clk) begin : sb
        logic push_m;
        logic pop_m;
        logic had_room;
        if (!rst) begin
            exp_q.delete();
            m_seq    = 4'd0;
            m_ovf    = 1'b0;
            m_skip   = 1'b0;
            prev_we  = 1'b0;
            wait_cnt = 0;
        end else begin
            chk("count", 32'(mb.fifo_count), 32'(exp_q.size()));
            chk("full", 32'(mb.fifo_full), 32'(exp_q.size() == DEPTH));
            chk("overflow", 32'(mb.overflow), 32'(m_ovf));
            if (mb.we_kb) begin
                chk("we_single_cycle", 32'(prev_we), 32'd0);
                chk("we_mbox_empty", mem_word, 32'h0);
                if (exp_q.size() > 0) chk("wr_data", mb.data_kb, exp_word(m_seq, exp_q[0]));
                else chk("wr_fifo_nonempty", 32'(exp_q.size()), 32'd1);
            end
            if (mem_word == 32'h0 && exp_q.size() > 0) begin
                if (wait_cnt >= 1) chk("write_latency", 32'(mb.we_kb), 32'd1);
                wait_cnt = mb.we_kb ? 0 : wait_cnt + 1;
            end else begin
                wait_cnt = 0;
            end
            prev_we = mb.we_kb;

            pop_m  = mb.we_kb;
            push_m = mb.key_valid;
`ifdef KB_BREAK_FILTER_EN
            if (mb.key_valid) begin
                if (m_skip) begin
                    push_m = 1'b0;
                    m_skip = 1'b0;
                end else if (mb.key_code == 8'hF0) begin
                    push_m = 1'b0;
                    m_skip = 1'b1;
                end
            end
`endif
            had_room = (exp_q.size() < DEPTH);
            if (pop_m && exp_q.size() > 0) void'(exp_q.pop_front());
            if (push_m && (had_room || pop_m)) exp_q.push_back(mb.key_code);
            if (push_m && !had_room && !pop_m) m_ovf = 1'b1;
            else if (mb.ovf_clr) m_ovf = 1'b0;
            if (pop_m) m_seq = m_seq + 4'd1;
        end
    end

    // driver tasks
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_key(input logic [7:0] c);
        mb.key_valid = 1'b1;
        mb.key_code  = c;
        tick(1);
        mb.key_valid = 1'b0;
    endtask

    task automatic cpu_clear();
        cpu_clr = 1'b1;
        tick(1);
        cpu_clr = 1'b0;
    endtask

    task automatic wait_write(input string tag, input logic [31:0] exp);
        int n;
        n = 0;
        do begin
            tick(1);
            n++;
        end while (!mb.we_kb && n < 8);
        chk({tag, "_seen"}, 32'(mb.we_kb), 32'd1);
        chk(tag, mb.data_kb, exp);
        tick(1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time=%0t limit=100000", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        mb.key_valid = 1'b0;
        mb.key_code  = 8'h00;
        mb.ovf_clr   = 1'b0;

        // reset values
        tick(2);
        chk("rst_we", 32'(mb.we_kb), 32'd0);
        chk("rst_data", mb.data_kb, 32'h0);
        chk("rst_addr", mb.addr_kb, MBOX);
        chk("rst_busy", 32'(mb.busy), 32'd0);
        chk("rst_count", 32'(mb.fifo_count), 32'd0);
        chk("rst_ovf", 32'(mb.overflow), 32'd0);
        chk("rst_state", 32'(mb.dbg.state), 32'(IDLE));
        rst = 1'b1;
        tick(1);

        // single key into an empty mailbox: write two cycles after the strobe
        send_key(8'h1C);
        chk("lat_idle_we", 32'(mb.we_kb), 32'd0);
        tick(1);
        chk("lat_write_we", 32'(mb.we_kb), 32'd1);
        chk("lat_write_data", mb.data_kb, 32'h0000_011C);
        chk("lat_write_busy", 32'(mb.busy), 32'd1);
        tick(1);
        chk("lat_hold_we", 32'(mb.we_kb), 32'd0);
        chk("lat_mem", mem_word, 32'h0000_011C);
        chk("lat_seq", 32'(mb.dbg.seq), 32'd1);

        // mailbox occupied: keys queue until the CPU clears it
        send_key(8'h32);
        send_key(8'h21);
        tick(2);
        chk("held_we", 32'(mb.we_kb), 32'd0);
        chk("held_count", 32'(mb.fifo_count), 32'd2);
        chk("held_head", mb.data_kb, 32'h0000_1132);
        cpu_clear();
        wait_write("wr_1132", 32'h0000_1132);
        cpu_clear();
        wait_write("wr_2121", 32'h0000_2121);

        // overflow with mailbox occupied, then clear
        tick(1);
        send_key(8'h11);
        send_key(8'h22);
        send_key(8'h33);
        send_key(8'h44);
        send_key(8'h55);
        chk("ovf_full", 32'(mb.fifo_full), 32'd1);
        chk("ovf_set", 32'(mb.overflow), 32'd1);
        chk("ovf_count", 32'(mb.fifo_count), 32'd4);
        mb.ovf_clr = 1'b1;
        tick(1);
        mb.ovf_clr = 1'b0;
        chk("ovf_cleared", 32'(mb.overflow), 32'd0);

        // push while full in the same cycle as the WRITE pop
        cpu_clear();
        tick(1);
        chk("pp_we", 32'(mb.we_kb), 32'd1);
        chk("pp_data", mb.data_kb, 32'h0000_3111);
        mb.key_valid = 1'b1;
        mb.key_code  = 8'h66;
        tick(1);
        mb.key_valid = 1'b0;
        chk("pp_count", 32'(mb.fifo_count), 32'd4);
        chk("pp_ovf", 32'(mb.overflow), 32'd0);

        // reset in the middle of WRITE
        tick(1);
        cpu_clear();
        tick(1);
        chk("mid_we", 32'(mb.we_kb), 32'd1);
        #2 rst = 1'b0;
        #1 chk("rst_async_we", 32'(mb.we_kb), 32'd0);
        tick(1);
        rst = 1'b1;
        chk("post_rst_count", 32'(mb.fifo_count), 32'd0);
        chk("post_rst_seq", 32'(mb.dbg.seq), 32'd0);
        chk("post_rst_busy", 32'(mb.busy), 32'd0);
        chk("post_rst_data", mb.data_kb, 32'h0);
        chk("post_rst_mem", mem_word, 32'h0);
        send_key(8'h00);
        tick(1);
        chk("zero_code_we", 32'(mb.we_kb), 32'd1);
        chk("zero_code_data", mb.data_kb, 32'h0000_0100);
        tick(1);

        // break code sequence
        base = wr_log.size();
        cpu_clear();
        send_key(8'hF0);
        send_key(8'h1C);
        send_key(8'h2A);
        repeat (3) begin
            tick(2);
            cpu_clear();
        end
        tick(4);
`ifdef KB_BREAK_FILTER_EN
        chk("brk_nwr", 32'(wr_log.size() - base), 32'd1);
        if (wr_log.size() > base) chk("brk_wr0", wr_log[base], 32'h0000_112A);
`else
        chk("brk_nwr", 32'(wr_log.size() - base), 32'd3);
        if (wr_log.size() >= base + 3) begin
            chk("brk_wr0", wr_log[base],     32'h0000_11F0);
            chk("brk_wr1", wr_log[base + 1], 32'h0000_211C);
            chk("brk_wr2", wr_log[base + 2], 32'h0000_312A);
        end
`endif

        // random traffic
        for (int i = 0; i < 800; i++) begin
            mb.key_valid = ($urandom_range(0, 99) < 35);
            mb.key_code  = ($urandom_range(0, 9) == 0) ? 8'hF0 : 8'($urandom_range(0, 255));
            cpu_clr      = ($urandom_range(0, 99) < 20);
            mb.ovf_clr   = ($urandom_range(0, 99) < 5);
            tick(1);
        end
        mb.key_valid = 1'b0;
        mb.ovf_clr   = 1'b0;
        cpu_clr      = 1'b0;
        tick(4);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
